// File: rtl/crc32.sv
// Streaming CRC-32/BZIP2 generator and checker.
// Consumes one dibit per valid cycle (axiid[0] is the earlier bit) and
// continuously presents the complemented LFSR state as the running CRC.
// Feeding a message followed by its own CRC leaves axiod at 0x38FB2284.
module crc32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        axiov,
    output logic [31:0] axiod
);

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] INIT = 32'hFFFF_FFFF;

    logic [31:0] state;

    // One serial LFSR step for a single message bit, MSB-first, unreflected.
    function automatic logic [31:0] crc_step(input logic [31:0] s, input logic b);
        logic fb;
        fb = s[31] ^ b;
        crc_step = {s[30:0], 1'b0} ^ (fb ? POLY : 32'h0000_0000);
    endfunction

    // Two bits per valid cycle: the earlier bit is folded in before the later one.
    function automatic logic [31:0] crc_dibit(input logic [31:0] s, input logic [1:0] d);
        crc_dibit = crc_step(crc_step(s, d[0]), d[1]);
    endfunction

    // LFSR state and output-valid flag; reset wins over an incoming dibit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            axiov <= 1'b0;
        end else begin
            axiov <= 1'b1;
            if (axiiv) begin
                state <= crc_dibit(state, axiid);
            end
        end
    end

    assign axiod = ~state;

endmodule

// File: tb/tb_crc32.sv
// Self-checking bench for crc32: a byte-table CRC model over the bits
// consumed since the last reset, checked every cycle, plus literal values.
module tb_crc32;

    logic        clk;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        axiov;
    logic [31:0] axiod;

    crc32 dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    int checks   = 0;
    int failures = 0;

    logic [31:0] tbl [256];
    bit          mq [$];      // message bits consumed since reset, in stream order
    logic        exp_vld = 1'b0;
    logic        started = 1'b0;

    logic [7:0] msg  [8] = '{8'h67, 8'h69, 8'h60, 8'hD1, 8'h9D, 8'h78, 8'h5A, 8'h5B};
    logic [7:0] fcs  [4] = '{8'h96, 8'hCB, 8'h5E, 8'h37};
    logic [7:0] std9 [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Classic polynomial-division lookup table, one entry per leading byte.
    function automatic void build_table();
        logic [31:0] c;
        for (int v = 0; v < 256; v++) begin
            c = 32'(v) << 24;
            for (int k = 0; k < 8; k++)
                c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
            tbl[v] = c;
        end
    endfunction

    // Expected axiod: whole bytes via the table, any trailing bits one at a time.
    function automatic logic [31:0] model_crc();
        logic [31:0] c;
        logic [7:0]  by;
        int          nb;
        c  = 32'hFFFF_FFFF;
        nb = mq.size() / 8;
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 8; k++) by[7-k] = mq[8*i + k];
            c = (c << 8) ^ tbl[c[31:24] ^ by];
        end
        for (int i = nb * 8; i < mq.size(); i++)
            c = (c[31] ^ mq[i]) ? ((c << 1) ^ POLY) : (c << 1);
        return ~c;
    endfunction

    // Model update: observe what the DUT sees at each rising edge.
    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            mq.delete();
            exp_vld <= 1'b0;
        end else begin
            exp_vld <= 1'b1;
            if (axiiv) begin
                mq.push_back(axiid[0]);
                mq.push_back(axiid[1]);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("axiov_model", {31'b0, axiov}, {31'b0, exp_vld});
            chk("axiod_model", axiod, model_crc());
            if ($isunknown({axiov, axiod})) begin
                checks++;
                failures++;
                $display("FAIL no_x: got axiov=%b axiod=%h expected no X", axiov, axiod);
            end
        end
    end

    task automatic send_dibit(input logic [1:0] d);
        axiiv = 1'b1;
        axiid = d;
        @(negedge clk);
        axiiv = 1'b0;
    endtask

    task automatic idle(input int n);
        axiiv = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        send_dibit({b[6], b[7]});
        if (gaps) idle($urandom_range(1, 5));
        send_dibit({b[4], b[5]});
        if (gaps) idle($urandom_range(1, 5));
        send_dibit({b[2], b[3]});
        if (gaps) idle($urandom_range(1, 5));
        send_dibit({b[0], b[1]});
        if (gaps) idle($urandom_range(1, 5));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        axiiv = 1'b0;
        @(negedge clk);
        chk("rst_axiod", axiod, 32'h0000_0000);
        chk("rst_axiov", {31'b0, axiov}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_axiov", {31'b0, axiov}, 32'd1);
        chk("post_rst_axiod", axiod, 32'h0000_0000);
    endtask

    task automatic check_hold(input string name, input logic [31:0] exp);
        idle(1);
        chk(name, axiod, exp);
        idle(2);
        chk({name, "_hold"}, axiod, exp);
    endtask

    initial begin
        build_table();
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 2'b00;
        repeat (2) @(negedge clk);

        // Generation, back-to-back.
        do_reset();
        foreach (msg[i]) send_byte(msg[i], 1'b0);
        chk("gen_model_pin", model_crc(), 32'h96CB5E37);
        check_hold("gen", 32'h96CB5E37);

        // Residue: message followed by its CRC.
        do_reset();
        foreach (msg[i]) send_byte(msg[i], 1'b0);
        foreach (fcs[i]) send_byte(fcs[i], 1'b0);
        chk("res_model_pin", model_crc(), 32'h38FB2284);
        check_hold("residue", 32'h38FB2284);

        // Standard check string "123456789".
        do_reset();
        foreach (std9[i]) send_byte(std9[i], 1'b0);
        chk("std_model_pin", model_crc(), 32'hFC891918);
        check_hold("std_check", 32'hFC891918);

        // Generation with random idle gaps between dibits.
        do_reset();
        foreach (msg[i]) send_byte(msg[i], 1'b1);
        check_hold("gaps", 32'h96CB5E37);

        // Reset mid-stream, asserted together with a valid dibit.
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(msg[i], 1'b0);
        rst   = 1'b1;
        axiiv = 1'b1;
        axiid = 2'b11;
        @(negedge clk);
        chk("mid_rst_axiod", axiod, 32'h0000_0000);
        chk("mid_rst_axiov", {31'b0, axiov}, 32'd0);
        rst   = 1'b0;
        axiiv = 1'b0;
        foreach (msg[i]) send_byte(msg[i], 1'b0);
        check_hold("mid_rst", 32'h96CB5E37);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
